// File: rtl/apb_pkg.sv
//------------------------------------------------------------------------------
// Package : apb_pkg
// Brief   : Shared APB widths, requester state encoding and command record.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_cmd_t;

endpackage

`default_nettype wire

// File: rtl/apb_cmd_master.sv
//------------------------------------------------------------------------------
// Module : apb_cmd_master
// Brief  : Single-outstanding APB4 requester bridging a valid/ready command
//          stream to APB transfers and returning data/error on a response
//          stream. Optional ACCESS timeout enabled by `define APB_TIMEOUT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_cmd_master
  import apb_pkg::*;
#(
  parameter logic [2:0]  PPROT_VAL      = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  input  logic [APB_SW-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [APB_AW-1:0] PADDR,
  output logic [2:0]        PPROT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  output logic [APB_SW-1:0] PSTRB,
  input  logic              PREADY,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_mst_state_e    state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic [APB_SW-1:0] pstrb_q, pstrb_d;
  apb_cmd_t          cmd_in;

`ifdef APB_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          // Reads never drive write data or strobes onto the bus.
          cmd_ready_d = 1'b0;
          paddr_d     = cmd_in.addr;
          pwrite_d    = cmd_in.write;
          pwdata_d    = cmd_in.write ? cmd_in.wdata : '0;
          pstrb_d     = cmd_in.write ? cmd_in.strb : '0;
          pprot_d     = PPROT_VAL;
          psel_d      = 1'b1;
          state_d     = SETUP;
`ifdef APB_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PPROT     = pprot_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
//------------------------------------------------------------------------------
// Module : tb_apb_cmd_master
// Brief  : Bench for apb_cmd_master with a small FIFO/register APB slave
//          model whose PREADY can be stalled. Covers APB_TIMEOUT_EN when set.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = -100;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_cmd_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Slave model: reg window addr 0 = FIFO-empty flag, offsets >= 0x40 error;
  // data window pushes on write, pops on read, errors on empty read/full write.
  logic [31:0] smem [8];
  int s_wp = 0, s_rp = 0, s_cnt = 0;
  int acc_cnt = 0;
  int stall_cycles = 0;

  assign PREADY = PSEL && PENABLE && (acc_cnt >= stall_cycles);

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (PSEL && PENABLE) begin
      if (PADDR[31]) begin
        if (!PWRITE) begin
          if (s_cnt == 0) PSLVERR = 1'b1;
          else            PRDATA  = smem[s_rp[2:0]];
        end else if (s_cnt == 8) begin
          PSLVERR = 1'b1;
        end
      end else if (PADDR[7:0] >= 8'h40) begin
        PSLVERR = 1'b1;
      end else if (!PWRITE && PADDR[7:0] == 8'h00) begin
        PRDATA = {31'b0, s_cnt == 0};
      end
    end
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && !PSLVERR && PADDR[31]) begin
      if (PWRITE) begin
        smem[s_wp[2:0]] <= PWDATA;
        s_wp  <= s_wp + 1;
        s_cnt <= s_cnt + 1;
      end else begin
        s_rp  <= s_rp + 1;
        s_cnt <= s_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  logic psel_prev = 1'b0;
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) chk("setup_gap", psel_prev, 1'b0);
    psel_prev <= PSEL;
  end

  task automatic do_xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee,
                         input int stall, input int exp_lat, input int hold, input bit tput);
    int n;
    int acc_cyc;
    stall_cycles = stall;
    if (hold > 0) rsp_ready = 1'b0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_valid = 1'b1;
    sb.push_back('{rdata: er, err: ee});
    n = 0;
    do begin @(negedge PCLK); n++; end while (!cmd_ready && n < 40);
    chk({tag, "_accept"}, cmd_ready, 1'b1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    if (tput) chk({tag, "_tput"}, acc_cyc - last_acc, 32'd4);
    last_acc = acc_cyc;
    n = 0;
    do begin
      @(negedge PCLK); n++;
      if (!rsp_valid) begin
        chk({tag, "_psel"}, PSEL, 1'b1);
        chk({tag, "_penable"}, PENABLE, n > 1);
        chk({tag, "_paddr"}, PADDR, a);
        chk({tag, "_pwrite"}, PWRITE, w);
        chk({tag, "_pwdata"}, PWDATA, w ? d : 32'h0);
        chk({tag, "_pstrb"}, PSTRB, w ? s : 4'h0);
        chk({tag, "_pprot"}, PPROT, 3'b000);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      end
    end while (!rsp_valid && n < 60);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_psel_off"}, {PSEL, PENABLE}, 2'b00);
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
      repeat (hold) begin
        @(negedge PCLK);
        chk({tag, "_hold_valid"}, rsp_valid, 1'b1);
        chk({tag, "_hold_cmd_ready"}, cmd_ready, 1'b0);
        chk({tag, "_hold_rdata"}, rsp_rdata, er);
        chk({tag, "_hold_err"}, rsp_err, ee);
      end
      @(posedge PCLK); #1;
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge PCLK);
    end
    @(posedge PCLK); #1;
    stall_cycles = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_rdata, rsp_err}, 33'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb_pprot", {PSTRB, PPROT}, 7'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    do_xfer("rd_stat0", 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h1, 1'b0, 0, 3, 0, 1'b0);
    do_xfer("wr_data",  1'b1, 32'h8000_0000, 32'h0000_00A5, 4'hF, 32'h0, 1'b0, 0, 3, 0, 1'b1);
    do_xfer("rd_stat1", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1'b0, 0, 3, 0, 1'b1);
    do_xfer("rd_data",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 32'hA5, 1'b0, 0, 3, 0, 1'b1);
    do_xfer("wr_err",   1'b1, 32'h0000_0040, 32'h1, 4'hF, 32'h0, 1'b1, 0, 3, 0, 1'b1);
    do_xfer("rd_err",   1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0, 1'b1, 0, 3, 0, 1'b1);
    do_xfer("wr_stall", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 3, 6, 0, 1'b0);
    do_xfer("rd_hold",  1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0, 3, 5, 1'b0);
    do_xfer("rd_stat2", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h1, 1'b0, 0, 3, 0, 1'b0);
`ifdef APB_TIMEOUT_EN
    do_xfer("tmo",      1'b1, 32'h8000_0000, 32'h55, 4'hF, 32'h0, 1'b1, 1000, 18, 0, 1'b0);
    do_xfer("tmo_edge", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h1, 1'b0, 15, 18, 0, 1'b0);
`endif

    // Reset asserted while the slave stalls in ACCESS must drop the transfer.
    stall_cycles = 1000;
    cmd_write = 1'b0; cmd_addr = 32'h0; cmd_valid = 1'b1;
    n = 0;
    do begin @(negedge PCLK); n++; end while (!cmd_ready && n < 40);
    chk("rst_xfer_accept", cmd_ready, 1'b1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_xfer_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_async_psel", {PSEL, PENABLE}, 2'b00);
    chk("rst_async_cmd_ready", cmd_ready, 1'b1);
    chk("rst_async_rsp_valid", rsp_valid, 1'b0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    stall_cycles = 0;
    repeat (6) begin
      @(negedge PCLK);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge PCLK); #1;
    do_xfer("rd_post_rst", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h1, 1'b0, 0, 3, 0, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
